// File: rtl/uart_cmd_responder_if.sv
// ---------------------------------------------------------------------------
// uart_cmd_responder_if
// Groups the three buses around the command responder:
//   - UART receive side : rx_p_data, rx_d_vld, par_err, stp_err
//   - UART transmit side: tx_p_data, tx_d_vld, tx_busy
//   - register file port: addr, wr_en, wr_data, rd_en, rd_data, rd_data_vld
//   - status            : frame_err
// modport master : the command responder itself
// modport slave  : the surrounding system (UART top + register file)
// ---------------------------------------------------------------------------
interface uart_cmd_responder_if #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 4
);
  logic [DATA_WIDTH-1:0] rx_p_data;
  logic                  rx_d_vld;
  logic                  par_err;
  logic                  stp_err;
  logic [DATA_WIDTH-1:0] tx_p_data;
  logic                  tx_d_vld;
  logic                  tx_busy;
  logic [ADDR_WIDTH-1:0] addr;
  logic                  wr_en;
  logic [DATA_WIDTH-1:0] wr_data;
  logic                  rd_en;
  logic [DATA_WIDTH-1:0] rd_data;
  logic                  rd_data_vld;
  logic                  frame_err;

  modport master (
    input  rx_p_data, rx_d_vld, par_err, stp_err,
    output tx_p_data, tx_d_vld,
    input  tx_busy,
    output addr, wr_en, wr_data, rd_en,
    input  rd_data, rd_data_vld,
    output frame_err
  );

  modport slave (
    output rx_p_data, rx_d_vld, par_err, stp_err,
    input  tx_p_data, tx_d_vld,
    output tx_busy,
    input  addr, wr_en, wr_data, rd_en,
    output rd_data, rd_data_vld,
    input  frame_err
  );
endinterface

// File: rtl/uart_cmd_responder.sv
// ---------------------------------------------------------------------------
// uart_cmd_responder
// Parses UART command frames and drives a register-file port.
//   write frame: WR_CMD, addr, data  -> one wr_en pulse, no reply
//   read  frame: RD_CMD, addr        -> one rd_en pulse, reply byte is the
//                                       read data, or ERR_RESP on timeout
// Ports:
//   clk  - system clock
//   rst  - synchronous active-high reset (drops any frame / pending reply)
//   bus  - uart_cmd_responder_if.master (RX bytes, TX handshake,
//          register-file port, frame_err pulse)
// All outputs come straight from registers.
// ---------------------------------------------------------------------------
module uart_cmd_responder #(
  parameter int                    DATA_WIDTH = 8,
  parameter int                    ADDR_WIDTH = 4,
  parameter int                    RD_TIMEOUT = 16,
  parameter logic [DATA_WIDTH-1:0] WR_CMD     = 8'hAA,
  parameter logic [DATA_WIDTH-1:0] RD_CMD     = 8'hBB,
  parameter logic [DATA_WIDTH-1:0] ERR_RESP   = 8'hFF
) (
  input  logic                  clk,
  input  logic                  rst,
  uart_cmd_responder_if.master  bus
);

  localparam logic [2:0] S_IDLE    = 3'd0;
  localparam logic [2:0] S_WR_ADDR = 3'd1;
  localparam logic [2:0] S_WR_DATA = 3'd2;
  localparam logic [2:0] S_RD_ADDR = 3'd3;
  localparam logic [2:0] S_RD_WAIT = 3'd4;
  localparam logic [2:0] S_TX_REQ  = 3'd5;
  localparam logic [2:0] S_TX_WAIT = 3'd6;

  localparam int              CNT_W        = (RD_TIMEOUT > 1) ? $clog2(RD_TIMEOUT) : 1;
  localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(RD_TIMEOUT - 1);

  logic [2:0]            state_r,     state_s;
  logic [CNT_W-1:0]      cnt_r,       cnt_s;
  logic [ADDR_WIDTH-1:0] addr_r,      addr_s;
  logic [DATA_WIDTH-1:0] wr_data_r,   wr_data_s;
  logic [DATA_WIDTH-1:0] tx_data_r,   tx_data_s;
  logic                  tx_vld_r,    tx_vld_s;
  logic                  wr_en_r,     wr_en_s;
  logic                  rd_en_r,     rd_en_s;
  logic                  frame_err_r, frame_err_s;
  logic                  rx_ok_s;
  logic                  rx_bad_s;

  // Classify the incoming byte; only meaningful while a frame is being parsed
  assign rx_ok_s  = bus.rx_d_vld & ~bus.par_err & ~bus.stp_err;
  assign rx_bad_s = bus.rx_d_vld & (bus.par_err | bus.stp_err);

  // Next-state and next-output computation for the frame parser
  always_comb begin
    state_s     = state_r;
    cnt_s       = cnt_r;
    addr_s      = addr_r;
    wr_data_s   = wr_data_r;
    tx_data_s   = tx_data_r;
    tx_vld_s    = tx_vld_r;
    wr_en_s     = 1'b0;
    rd_en_s     = 1'b0;
    frame_err_s = 1'b0;

    case (state_r)
      S_IDLE: begin
        if (rx_bad_s) begin
          frame_err_s = 1'b1;
          state_s     = S_IDLE;
        end else if (rx_ok_s) begin
          if (bus.rx_p_data == WR_CMD) begin
            state_s = S_WR_ADDR;
          end else if (bus.rx_p_data == RD_CMD) begin
            state_s = S_RD_ADDR;
          end else begin
            state_s = S_IDLE;
          end
        end else begin
          state_s = S_IDLE;
        end
      end

      S_WR_ADDR: begin
        if (rx_bad_s) begin
          frame_err_s = 1'b1;
          state_s     = S_IDLE;
        end else if (rx_ok_s) begin
          addr_s  = bus.rx_p_data[ADDR_WIDTH-1:0];
          state_s = S_WR_DATA;
        end else begin
          state_s = S_WR_ADDR;
        end
      end

      S_WR_DATA: begin
        if (rx_bad_s) begin
          frame_err_s = 1'b1;
          state_s     = S_IDLE;
        end else if (rx_ok_s) begin
          wr_data_s = bus.rx_p_data;
          wr_en_s   = 1'b1;
          state_s   = S_IDLE;
        end else begin
          state_s = S_WR_DATA;
        end
      end

      S_RD_ADDR: begin
        if (rx_bad_s) begin
          frame_err_s = 1'b1;
          state_s     = S_IDLE;
        end else if (rx_ok_s) begin
          addr_s  = bus.rx_p_data[ADDR_WIDTH-1:0];
          rd_en_s = 1'b1;
          cnt_s   = {CNT_W{1'b0}};
          state_s = S_RD_WAIT;
        end else begin
          state_s = S_RD_ADDR;
        end
      end

      // Real read data has priority over a timeout expiring in the same cycle
      S_RD_WAIT: begin
        if (bus.rd_data_vld) begin
          tx_data_s = bus.rd_data;
          tx_vld_s  = 1'b1;
          state_s   = S_TX_REQ;
        end else if (cnt_r == TIMEOUT_LAST) begin
          tx_data_s = ERR_RESP;
          tx_vld_s  = 1'b1;
          state_s   = S_TX_REQ;
        end else begin
          cnt_s   = cnt_r + CNT_W'(1);
          state_s = S_RD_WAIT;
        end
      end

      // Hold the request until the transmitter reports it has taken the byte
      S_TX_REQ: begin
        if (bus.tx_busy) begin
          tx_vld_s = 1'b0;
          state_s  = S_TX_WAIT;
        end else begin
          tx_vld_s = 1'b1;
          state_s  = S_TX_REQ;
        end
      end

      S_TX_WAIT: begin
        if (!bus.tx_busy) begin
          state_s = S_IDLE;
        end else begin
          state_s = S_TX_WAIT;
        end
      end

      default: begin
        tx_vld_s = 1'b0;
        state_s  = S_IDLE;
      end
    endcase
  end

  // State and output registers with synchronous reset
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r     <= S_IDLE;
      cnt_r       <= {CNT_W{1'b0}};
      addr_r      <= {ADDR_WIDTH{1'b0}};
      wr_data_r   <= {DATA_WIDTH{1'b0}};
      tx_data_r   <= {DATA_WIDTH{1'b0}};
      tx_vld_r    <= 1'b0;
      wr_en_r     <= 1'b0;
      rd_en_r     <= 1'b0;
      frame_err_r <= 1'b0;
    end else begin
      state_r     <= state_s;
      cnt_r       <= cnt_s;
      addr_r      <= addr_s;
      wr_data_r   <= wr_data_s;
      tx_data_r   <= tx_data_s;
      tx_vld_r    <= tx_vld_s;
      wr_en_r     <= wr_en_s;
      rd_en_r     <= rd_en_s;
      frame_err_r <= frame_err_s;
    end
  end

  assign bus.addr      = addr_r;
  assign bus.wr_data   = wr_data_r;
  assign bus.wr_en     = wr_en_r;
  assign bus.rd_en     = rd_en_r;
  assign bus.tx_p_data = tx_data_r;
  assign bus.tx_d_vld  = tx_vld_r;
  assign bus.frame_err = frame_err_r;

endmodule

// File: tb/tb_uart_cmd_responder.sv
// ---------------------------------------------------------------------------
// tb_uart_cmd_responder
// Directed bench for uart_cmd_responder: write/read frames, read timeout,
// errored bytes, bytes arriving while a reply is pending, and reset while a
// transmit request is outstanding.
// ---------------------------------------------------------------------------
module tb_uart_cmd_responder;

  logic clk = 1'b0;
  logic rst = 1'b1;

  int checks = 0;
  int errors = 0;
  int wr_cnt = 0;
  int tx_cyc = 0;
  int fe_cnt = 0;

  uart_cmd_responder_if #(.DATA_WIDTH(8), .ADDR_WIDTH(4)) bus_if ();

  uart_cmd_responder #(
    .DATA_WIDTH(8),
    .ADDR_WIDTH(4),
    .RD_TIMEOUT(16),
    .WR_CMD    (8'hAA),
    .RD_CMD    (8'hBB),
    .ERR_RESP  (8'hFF)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus_if)
  );

  always #5 clk = ~clk;

  // Count strobe/request cycles as seen by the clock edge
  always @(posedge clk) begin
    if (bus_if.wr_en)     wr_cnt++;
    if (bus_if.tx_d_vld)  tx_cyc++;
    if (bus_if.frame_err) fe_cnt++;
  end

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_byte(input logic [7:0] b, input logic perr, input logic serr);
    bus_if.rx_p_data = b;
    bus_if.rx_d_vld  = 1'b1;
    bus_if.par_err   = perr;
    bus_if.stp_err   = serr;
    tick();
    bus_if.rx_d_vld  = 1'b0;
    bus_if.par_err   = 1'b0;
    bus_if.stp_err   = 1'b0;
  endtask

  // Transmitter takes the byte, then goes idle; responder returns to IDLE
  task automatic tx_handshake(input string tag);
    bus_if.tx_busy = 1'b1;
    tick();
    check({tag, "_vld_drop"}, bus_if.tx_d_vld, 1'b0);
    bus_if.tx_busy = 1'b0;
    tick();
  endtask

  initial begin
    bus_if.rx_p_data   = 8'h00;
    bus_if.rx_d_vld    = 1'b0;
    bus_if.par_err     = 1'b0;
    bus_if.stp_err     = 1'b0;
    bus_if.tx_busy     = 1'b0;
    bus_if.rd_data     = 8'h00;
    bus_if.rd_data_vld = 1'b0;

    // Reset values
    repeat (3) tick();
    check("rst_tx_vld",  bus_if.tx_d_vld,  1'b0);
    check("rst_wr_en",   bus_if.wr_en,     1'b0);
    check("rst_rd_en",   bus_if.rd_en,     1'b0);
    check("rst_fe",      bus_if.frame_err, 1'b0);
    check("rst_addr",    bus_if.addr,      4'h0);
    check("rst_wr_data", bus_if.wr_data,   8'h00);
    check("rst_tx_data", bus_if.tx_p_data, 8'h00);
    rst = 1'b0;
    tick();

    // Write frame AA,05,3C
    send_byte(8'hAA, 1'b0, 1'b0);
    send_byte(8'h05, 1'b0, 1'b0);
    check("wr1_addr_early", bus_if.addr, 4'h5);
    send_byte(8'h3C, 1'b0, 1'b0);
    check("wr1_en",   bus_if.wr_en,   1'b1);
    check("wr1_addr", bus_if.addr,    4'h5);
    check("wr1_data", bus_if.wr_data, 8'h3C);
    tick();
    check("wr1_en_pulse", bus_if.wr_en, 1'b0);
    check("wr1_count",    wr_cnt,       32'd1);
    check("wr1_no_tx",    tx_cyc,       32'd0);

    // Read frame BB,07 with data arriving 3 cycles after rd_en
    send_byte(8'hBB, 1'b0, 1'b0);
    send_byte(8'h07, 1'b0, 1'b0);
    check("rd1_en",   bus_if.rd_en, 1'b1);
    check("rd1_addr", bus_if.addr,  4'h7);
    tick();
    check("rd1_en_pulse", bus_if.rd_en, 1'b0);
    tick();
    tick();
    bus_if.rd_data     = 8'hA5;
    bus_if.rd_data_vld = 1'b1;
    tick();
    bus_if.rd_data_vld = 1'b0;
    check("rd1_tx_vld",  bus_if.tx_d_vld,  1'b1);
    check("rd1_tx_data", bus_if.tx_p_data, 8'hA5);
    repeat (3) tick();
    check("rd1_tx_hold",      bus_if.tx_d_vld,  1'b1);
    check("rd1_tx_data_hold", bus_if.tx_p_data, 8'hA5);
    tx_handshake("rd1");

    // Read frame BB,02 with no data: error byte after the timeout
    send_byte(8'hBB, 1'b0, 1'b0);
    send_byte(8'h02, 1'b0, 1'b0);
    repeat (15) tick();
    check("to_not_yet", bus_if.tx_d_vld, 1'b0);
    tick();
    check("to_tx_vld",  bus_if.tx_d_vld,  1'b1);
    check("to_tx_data", bus_if.tx_p_data, 8'hFF);
    tx_handshake("to");

    // Data valid in the very cycle the timeout expires: data wins
    send_byte(8'hBB, 1'b0, 1'b0);
    send_byte(8'h03, 1'b0, 1'b0);
    repeat (15) tick();
    bus_if.rd_data     = 8'h5A;
    bus_if.rd_data_vld = 1'b1;
    tick();
    bus_if.rd_data_vld = 1'b0;
    check("race_tx_vld",  bus_if.tx_d_vld,  1'b1);
    check("race_tx_data", bus_if.tx_p_data, 8'h5A);
    tx_handshake("race");

    // Parity error on the address byte aborts the write
    send_byte(8'hAA, 1'b0, 1'b0);
    send_byte(8'h09, 1'b1, 1'b0);
    check("fe_pulse", bus_if.frame_err, 1'b1);
    tick();
    check("fe_pulse_end", bus_if.frame_err, 1'b0);
    // Next read works normally; data returned while rd_en is still high
    send_byte(8'hBB, 1'b0, 1'b0);
    send_byte(8'h01, 1'b0, 1'b0);
    check("fe_rd_en",   bus_if.rd_en, 1'b1);
    check("fe_rd_addr", bus_if.addr,  4'h1);
    bus_if.rd_data     = 8'h77;
    bus_if.rd_data_vld = 1'b1;
    tick();
    bus_if.rd_data_vld = 1'b0;
    check("fe_rd_tx", bus_if.tx_p_data, 8'h77);
    tx_handshake("fe_rd");
    // Stop error on the data byte aborts the write as well
    send_byte(8'hAA, 1'b0, 1'b0);
    send_byte(8'h04, 1'b0, 1'b0);
    send_byte(8'h55, 1'b0, 1'b1);
    check("fe_stp_pulse", bus_if.frame_err, 1'b1);
    check("fe_stp_no_wr", bus_if.wr_en,     1'b0);
    tick();
    check("fe_wr_count", wr_cnt, 32'd1);

    // Unknown byte ignored, then write to address F
    send_byte(8'h12, 1'b0, 1'b0);
    send_byte(8'hAA, 1'b0, 1'b0);
    send_byte(8'h0F, 1'b0, 1'b0);
    send_byte(8'h00, 1'b0, 1'b0);
    check("unk_wr_en",   bus_if.wr_en,   1'b1);
    check("unk_wr_addr", bus_if.addr,    4'hF);
    check("unk_wr_data", bus_if.wr_data, 8'h00);
    tick();
    // Upper address bits are dropped
    send_byte(8'hAA, 1'b0, 1'b0);
    send_byte(8'hE6, 1'b0, 1'b0);
    send_byte(8'h11, 1'b0, 1'b0);
    check("hi_addr", bus_if.addr,    4'h6);
    check("hi_data", bus_if.wr_data, 8'h11);
    tick();
    check("unk_wr_count", wr_cnt, 32'd3);

    // Bytes during TX_WAIT are dropped, even errored ones
    send_byte(8'hBB, 1'b0, 1'b0);
    send_byte(8'h0A, 1'b0, 1'b0);
    bus_if.rd_data     = 8'hC3;
    bus_if.rd_data_vld = 1'b1;
    tick();
    bus_if.rd_data_vld = 1'b0;
    check("tw_tx_data", bus_if.tx_p_data, 8'hC3);
    bus_if.tx_busy = 1'b1;
    tick();
    send_byte(8'hAA, 1'b0, 1'b0);
    send_byte(8'h5A, 1'b1, 1'b0);
    check("tw_no_fe", bus_if.frame_err, 1'b0);
    bus_if.tx_busy = 1'b0;
    tick();
    send_byte(8'h05, 1'b0, 1'b0);
    send_byte(8'h3C, 1'b0, 1'b0);
    tick();
    check("tw_wr_count", wr_cnt, 32'd3);
    check("tw_fe_count", fe_cnt, 32'd2);

    // Reset while a transmit request is pending
    send_byte(8'hBB, 1'b0, 1'b0);
    send_byte(8'h01, 1'b0, 1'b0);
    bus_if.rd_data     = 8'h99;
    bus_if.rd_data_vld = 1'b1;
    tick();
    bus_if.rd_data_vld = 1'b0;
    check("mr_tx_vld", bus_if.tx_d_vld, 1'b1);
    rst = 1'b1;
    tick();
    check("mr_tx_vld_clr",  bus_if.tx_d_vld,  1'b0);
    check("mr_tx_data_clr", bus_if.tx_p_data, 8'h00);
    check("mr_addr_clr",    bus_if.addr,      4'h0);
    check("mr_wr_data_clr", bus_if.wr_data,   8'h00);
    rst = 1'b0;
    tick();
    // Still in TX_REQ would keep tx_d_vld high; IDLE accepts a new write
    check("mr_idle_no_tx", bus_if.tx_d_vld, 1'b0);
    send_byte(8'hAA, 1'b0, 1'b0);
    send_byte(8'h02, 1'b0, 1'b0);
    send_byte(8'h44, 1'b0, 1'b0);
    check("mr_wr_en",   bus_if.wr_en,   1'b1);
    check("mr_wr_addr", bus_if.addr,    4'h2);
    check("mr_wr_data", bus_if.wr_data, 8'h44);
    tick();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
